ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
ID/EX pipeline register and operand-select stage that feeds the single-cycle ALU (A, B, 3-bit ALU operation).
- Latches decoded instructions on each advance.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards and inserts one bubble.
- Presents final ALU operands plus store data to the EX stage.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register address width (x0 hardwired zero)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid_i  in  1  decode slot holds a real instruction
id_rs1_i / id_rs2_i  in  REG_AW  source register addresses
id_use_rs1_i / id_use_rs2_i  in  1  instruction actually reads rs1/rs2
id_rs1_data_i / id_rs2_data_i  in  XLEN  register-file read data
id_imm_i  in  XLEN  sign-extended immediate
id_pc_i  in  XLEN  instruction PC
id_alu_src_a_i  in  1  0=rs1, 1=PC
id_alu_src_b_i  in  1  0=rs2, 1=imm
id_alu_op_i  in  3  ALU operation code, passed through
id_rd_i  in  REG_AW  destination register
id_reg_write_i / id_mem_read_i / id_mem_write_i  in  1  control flags
mem_rd_i, mem_reg_write_i, mem_result_i  in  REG_AW/1/XLEN  EX/MEM forward source
wb_rd_i, wb_reg_write_i, wb_data_i  in  REG_AW/1/XLEN  MEM/WB forward source
hold_i  in  1  downstream stall: freeze stage
flush_i  in  1  branch/jump kill of this stage's contents
stall_o  out  1  load-use hazard: upstream must hold PC and IF/ID
ex_valid_o  out  1  registered valid
ex_a_o / ex_b_o  out  XLEN  ALU operands
ex_alu_op_o  out  3  registered ALU operation
ex_store_data_o  out  XLEN  forwarded rs2 value for stores
ex_rd_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_pc_o, ex_imm_o  out  registered pass-through fields

Behaviour:
- Reset (async, rst_n=0): every registered field goes to 0, so ex_valid_o=0 and all control flags are 0. Combinational outputs therefore also read 0.
- Latency: one cycle from ID inputs to registered fields. ex_a_o, ex_b_o and ex_store_data_o are combinational from registered fields plus the forward inputs.
- stall_o is combinational and asserts when all of the following hold:
  - id_valid_i, ex_valid_o and ex_mem_read_o are 1;
  - ex_rd_o != 0;
  - ex_rd_o matches id_rs1_i with id_use_rs1_i set, or matches id_rs2_i with id_use_rs2_i set.
- Per-edge priority:
  - flush_i: load a bubble (valid, reg_write, mem_read, mem_write = 0). Flush overrides hold_i.
  - else hold_i: keep all fields. If valid, rs1_q/rs2_q are refreshed with their current forwarded values, so a producer retiring from WB during the hold is not lost.
  - else stall_o: load a bubble.
  - else capture the ID inputs. A field captures 0 when id_valid_i=0.
- Capture bypass: if wb_reg_write_i=1, wb_rd_i != 0 and wb_rd_i equals id_rsN_i, capture wb_data_i instead of id_rsN_data_i. This covers register-file write/read in the same cycle.
- Forward select for rsN_val:
  - 1st: mem_result_i when mem_reg_write_i=1, mem_rd_i != 0 and mem_rd_i == rsN_q;
  - 2nd: wb_data_i on the same conditions for WB;
  - else rsN_q.
  - EX/MEM beats MEM/WB. A source register of x0 is never forwarded.
- Operand outputs: ex_a_o = src_a ? pc_q : rs1_val; ex_b_o = src_b ? imm_q : rs2_val; ex_store_data_o = rs2_val.
- Bubble behaviour: a bubble's operand values are don't-care; downstream honours only the valid flag and control flags. Its rd is 0.
- Simultaneous stall_o and hold_i: hold wins. stall_o stays asserted while the hazard persists.
- Reset mid-stall: all state clears and stall_o deasserts immediately.

Decomposition:
- Shared package holds XLEN, REG_AW, ALU op encodings (AND=000, OR=001, ADD=010, XOR=011, NOR=100, SRL=101, SUB=110, SLTU=111) and the ALU source-select constants.
- One sub-module, fwd_mux: a single operand's EX/MEM, MEM/WB, register priority select. It is instantiated twice (rs1, rs2) and reused for capture bypass with the MEM inputs tied off.

Test Plan:
1. Reset: rst_n low mid-capture -> ex_valid_o=0, ex_a_o=0, ex_b_o=0, stall_o=0 without waiting for a clock edge.
2. Plain capture: rs1=x1 data 5, rs2=x2 data 3, alu_op=110, no forwards -> next cycle ex_a_o=5, ex_b_o=3, ex_alu_op_o=110.
3. Forward priority: ex rs1_q=x3; mem_rd=x3 result 0xAA; wb_rd=x3 data 0xBB -> ex_a_o=0xAA. Drop mem_reg_write -> ex_a_o=0xBB. Set rd=x0 on both -> register value.
4. Load-use: EX holds lw x4 (mem_read=1); ID add reads x4 -> stall_o=1 in that cycle. Next cycle ex_valid_o=0 and reg_write=0, and the add captures one cycle later.
5. Hold refresh: hold_i=1 for 3 cycles while wb writes rs2's register with 0x1234, then hold_i=0 with no forwards -> ex_b_o=0x1234.
6. Flush during hold: hold_i=1 and flush_i=1 on the same edge -> ex_valid_o=0, ex_reg_write_o=0 and ex_mem_write_o=0 next cycle.

Source files
------------

// File: rtl/ex_operand_stage_pkg.sv
// Shared widths, ALU op encodings, operand-select constants and the EX-stage field bundle
// for the ID/EX operand stage.
package ex_operand_stage_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef logic [XLEN-1:0]   xword_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_XOR  = 3'b011,
    ALU_NOR  = 3'b100,
    ALU_SRL  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLTU = 3'b111
  } alu_op_e;

  localparam logic SRC_A_RS1 = 1'b0;
  localparam logic SRC_A_PC  = 1'b1;
  localparam logic SRC_B_RS2 = 1'b0;
  localparam logic SRC_B_IMM = 1'b1;

  // Everything latched into the ID/EX register; all-zero is a bubble.
  typedef struct packed {
    logic      valid;
    reg_addr_t rs1;
    reg_addr_t rs2;
    xword_t    rs1_val;
    xword_t    rs2_val;
    xword_t    imm;
    xword_t    pc;
    logic      src_a;
    logic      src_b;
    logic [2:0] alu_op;
    reg_addr_t rd;
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
  } ex_fields_t;

  // x0 never matches, so a hardwired-zero source is never overridden.
  function automatic logic fwd_hit(input logic we, input reg_addr_t rd, input reg_addr_t rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// Signal bundle between decode/forwarding sources and the ID/EX operand stage.
interface ex_operand_stage_if;
  import ex_operand_stage_pkg::*;

  logic       id_valid_i;
  reg_addr_t  id_rs1_i, id_rs2_i;
  logic       id_use_rs1_i, id_use_rs2_i;
  xword_t     id_rs1_data_i, id_rs2_data_i;
  xword_t     id_imm_i, id_pc_i;
  logic       id_alu_src_a_i, id_alu_src_b_i;
  logic [2:0] id_alu_op_i;
  reg_addr_t  id_rd_i;
  logic       id_reg_write_i, id_mem_read_i, id_mem_write_i;
  reg_addr_t  mem_rd_i;
  logic       mem_reg_write_i;
  xword_t     mem_result_i;
  reg_addr_t  wb_rd_i;
  logic       wb_reg_write_i;
  xword_t     wb_data_i;
  logic       hold_i, flush_i;

  logic       stall_o;
  logic       ex_valid_o;
  xword_t     ex_a_o, ex_b_o, ex_store_data_o;
  logic [2:0] ex_alu_op_o;
  reg_addr_t  ex_rd_o;
  logic       ex_reg_write_o, ex_mem_read_o, ex_mem_write_o;
  xword_t     ex_pc_o, ex_imm_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           id_rs1_data_i, id_rs2_data_i, id_imm_i, id_pc_i,
           id_alu_src_a_i, id_alu_src_b_i, id_alu_op_i, id_rd_i,
           id_reg_write_i, id_mem_read_i, id_mem_write_i,
           mem_rd_i, mem_reg_write_i, mem_result_i,
           wb_rd_i, wb_reg_write_i, wb_data_i, hold_i, flush_i,
    input  stall_o, ex_valid_o, ex_a_o, ex_b_o, ex_store_data_o, ex_alu_op_o,
           ex_rd_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_pc_o, ex_imm_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           id_rs1_data_i, id_rs2_data_i, id_imm_i, id_pc_i,
           id_alu_src_a_i, id_alu_src_b_i, id_alu_op_i, id_rd_i,
           id_reg_write_i, id_mem_read_i, id_mem_write_i,
           mem_rd_i, mem_reg_write_i, mem_result_i,
           wb_rd_i, wb_reg_write_i, wb_data_i, hold_i, flush_i,
    output stall_o, ex_valid_o, ex_a_o, ex_b_o, ex_store_data_o, ex_alu_op_o,
           ex_rd_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_pc_o, ex_imm_o
  );

endinterface

// File: rtl/ex_operand_stage_fwd_mux.sv
// One operand's forward select: EX/MEM result, then MEM/WB data, then the held register value.
module ex_operand_stage_fwd_mux
  import ex_operand_stage_pkg::*;
(
  input  reg_addr_t i_rs,
  input  xword_t    i_reg_val,
  input  logic      i_mem_we,
  input  reg_addr_t i_mem_rd,
  input  xword_t    i_mem_val,
  input  logic      i_wb_we,
  input  reg_addr_t i_wb_rd,
  input  xword_t    i_wb_val,
  output xword_t    o_val
);

  always_comb begin
    o_val = i_reg_val;
    if (fwd_hit(i_mem_we, i_mem_rd, i_rs))
      o_val = i_mem_val;
    else if (fwd_hit(i_wb_we, i_wb_rd, i_rs))
      o_val = i_wb_val;
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with RAW forwarding, load-use bubble insertion and
// final ALU operand / store-data selection.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  ex_operand_stage_if.slave bus
);

  ex_fields_t r_ex_p1;
  ex_fields_t w_cap;
  xword_t     w_rs1_fwd, w_rs2_fwd;
  xword_t     w_rs1_byp, w_rs2_byp;
  logic       w_stall;
  logic       w_bubble;

  ex_operand_stage_fwd_mux u_fwd_rs1 (
    .i_rs(r_ex_p1.rs1), .i_reg_val(r_ex_p1.rs1_val),
    .i_mem_we(bus.mem_reg_write_i), .i_mem_rd(bus.mem_rd_i), .i_mem_val(bus.mem_result_i),
    .i_wb_we(bus.wb_reg_write_i), .i_wb_rd(bus.wb_rd_i), .i_wb_val(bus.wb_data_i),
    .o_val(w_rs1_fwd)
  );

  ex_operand_stage_fwd_mux u_fwd_rs2 (
    .i_rs(r_ex_p1.rs2), .i_reg_val(r_ex_p1.rs2_val),
    .i_mem_we(bus.mem_reg_write_i), .i_mem_rd(bus.mem_rd_i), .i_mem_val(bus.mem_result_i),
    .i_wb_we(bus.wb_reg_write_i), .i_wb_rd(bus.wb_rd_i), .i_wb_val(bus.wb_data_i),
    .o_val(w_rs2_fwd)
  );

  // Register file is written and read in the same cycle: take the WB value at capture.
  ex_operand_stage_fwd_mux u_byp_rs1 (
    .i_rs(bus.id_rs1_i), .i_reg_val(bus.id_rs1_data_i),
    .i_mem_we(1'b0), .i_mem_rd('0), .i_mem_val('0),
    .i_wb_we(bus.wb_reg_write_i), .i_wb_rd(bus.wb_rd_i), .i_wb_val(bus.wb_data_i),
    .o_val(w_rs1_byp)
  );

  ex_operand_stage_fwd_mux u_byp_rs2 (
    .i_rs(bus.id_rs2_i), .i_reg_val(bus.id_rs2_data_i),
    .i_mem_we(1'b0), .i_mem_rd('0), .i_mem_val('0),
    .i_wb_we(bus.wb_reg_write_i), .i_wb_rd(bus.wb_rd_i), .i_wb_val(bus.wb_data_i),
    .o_val(w_rs2_byp)
  );

  assign w_stall = bus.id_valid_i && r_ex_p1.valid && r_ex_p1.mem_read && (r_ex_p1.rd != '0) &&
                   ((bus.id_use_rs1_i && (bus.id_rs1_i == r_ex_p1.rd)) ||
                    (bus.id_use_rs2_i && (bus.id_rs2_i == r_ex_p1.rd)));

  // Flush beats hold; hold beats the load-use bubble; an empty decode slot also loads zeros.
  assign w_bubble = bus.flush_i || (!bus.hold_i && (w_stall || !bus.id_valid_i));

  always_comb begin
    w_cap           = '0;
    w_cap.valid     = 1'b1;
    w_cap.rs1       = bus.id_rs1_i;
    w_cap.rs2       = bus.id_rs2_i;
    w_cap.rs1_val   = w_rs1_byp;
    w_cap.rs2_val   = w_rs2_byp;
    w_cap.imm       = bus.id_imm_i;
    w_cap.pc        = bus.id_pc_i;
    w_cap.src_a     = bus.id_alu_src_a_i;
    w_cap.src_b     = bus.id_alu_src_b_i;
    w_cap.alu_op    = bus.id_alu_op_i;
    w_cap.rd        = bus.id_rd_i;
    w_cap.reg_write = bus.id_reg_write_i;
    w_cap.mem_read  = bus.id_mem_read_i;
    w_cap.mem_write = bus.id_mem_write_i;
  end

  // ID -> EX boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_p1 <= '0;
    end else if (w_bubble) begin
      r_ex_p1 <= '0;
    end else if (bus.hold_i) begin
      if (r_ex_p1.valid) begin
        r_ex_p1.rs1_val <= w_rs1_fwd;
        r_ex_p1.rs2_val <= w_rs2_fwd;
      end
    end else begin
      r_ex_p1 <= w_cap;
    end
  end

  assign bus.stall_o         = w_stall;
  assign bus.ex_valid_o      = r_ex_p1.valid;
  assign bus.ex_a_o          = (r_ex_p1.src_a == SRC_A_PC) ? r_ex_p1.pc : w_rs1_fwd;
  assign bus.ex_b_o          = (r_ex_p1.src_b == SRC_B_IMM) ? r_ex_p1.imm : w_rs2_fwd;
  assign bus.ex_store_data_o = w_rs2_fwd;
  assign bus.ex_alu_op_o     = r_ex_p1.alu_op;
  assign bus.ex_rd_o         = r_ex_p1.rd;
  assign bus.ex_reg_write_o  = r_ex_p1.reg_write;
  assign bus.ex_mem_read_o   = r_ex_p1.mem_read;
  assign bus.ex_mem_write_o  = r_ex_p1.mem_write;
  assign bus.ex_pc_o         = r_ex_p1.pc;
  assign bus.ex_imm_o        = r_ex_p1.imm;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios plus randomized traffic against a
// behavioural model of the stage's latch/forward/stall rules.
module tb_ex_operand_stage;
  import ex_operand_stage_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  ex_operand_stage_if bus ();

  ex_operand_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1, rs2;
    logic [31:0] v1, v2, imm, pc;
    logic        sa, sb;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        rw, mr, mw;
  } model_t;

  model_t m, nxt;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Value a source register should present given the live EX/MEM and MEM/WB producers.
  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] regv);
    if (rs != 0 && bus.mem_reg_write_i && bus.mem_rd_i == rs) return bus.mem_result_i;
    if (rs != 0 && bus.wb_reg_write_i && bus.wb_rd_i == rs) return bus.wb_data_i;
    return regv;
  endfunction

  function automatic logic exp_stall();
    return bus.id_valid_i && m.valid && m.mr && (m.rd != 0) &&
           ((bus.id_use_rs1_i && bus.id_rs1_i == m.rd) || (bus.id_use_rs2_i && bus.id_rs2_i == m.rd));
  endfunction

  function automatic logic [31:0] regfile_read(input logic [4:0] rs, input logic [31:0] rf_data);
    if (bus.wb_reg_write_i && rs != 0 && bus.wb_rd_i == rs) return bus.wb_data_i;
    return rf_data;
  endfunction

  task automatic check_model();
    check_val("valid", 64'(bus.ex_valid_o), 64'(m.valid));
    check_val("stall", 64'(bus.stall_o), 64'(exp_stall()));
    check_val("rd", 64'(bus.ex_rd_o), 64'(m.rd));
    check_val("reg_write", 64'(bus.ex_reg_write_o), 64'(m.rw));
    check_val("mem_read", 64'(bus.ex_mem_read_o), 64'(m.mr));
    check_val("mem_write", 64'(bus.ex_mem_write_o), 64'(m.mw));
    if (m.valid) begin
      check_val("ex_a", 64'(bus.ex_a_o), 64'(m.sa ? m.pc : fwd(m.rs1, m.v1)));
      check_val("ex_b", 64'(bus.ex_b_o), 64'(m.sb ? m.imm : fwd(m.rs2, m.v2)));
      check_val("store_data", 64'(bus.ex_store_data_o), 64'(fwd(m.rs2, m.v2)));
      check_val("alu_op", 64'(bus.ex_alu_op_o), 64'(m.op));
      check_val("pc", 64'(bus.ex_pc_o), 64'(m.pc));
      check_val("imm", 64'(bus.ex_imm_o), 64'(m.imm));
    end
  endtask

  task automatic next_model();
    nxt = m;
    if (bus.flush_i) begin
      nxt = '0;
    end else if (bus.hold_i) begin
      if (m.valid) begin
        nxt.v1 = fwd(m.rs1, m.v1);
        nxt.v2 = fwd(m.rs2, m.v2);
      end
    end else if (exp_stall() || !bus.id_valid_i) begin
      nxt = '0;
    end else begin
      nxt.valid = 1'b1;
      nxt.rs1   = bus.id_rs1_i;
      nxt.rs2   = bus.id_rs2_i;
      nxt.v1    = regfile_read(bus.id_rs1_i, bus.id_rs1_data_i);
      nxt.v2    = regfile_read(bus.id_rs2_i, bus.id_rs2_data_i);
      nxt.imm   = bus.id_imm_i;
      nxt.pc    = bus.id_pc_i;
      nxt.sa    = bus.id_alu_src_a_i;
      nxt.sb    = bus.id_alu_src_b_i;
      nxt.op    = bus.id_alu_op_i;
      nxt.rd    = bus.id_rd_i;
      nxt.rw    = bus.id_reg_write_i;
      nxt.mr    = bus.id_mem_read_i;
      nxt.mw    = bus.id_mem_write_i;
    end
  endtask

  // Inputs are set at posedge+1; check at negedge, advance model at posedge.
  task automatic tick();
    @(negedge clk);
    check_model();
    next_model();
    @(posedge clk);
    m = nxt;
    #1;
  endtask

  task automatic idle();
    bus.id_valid_i = 0; bus.id_rs1_i = 0; bus.id_rs2_i = 0;
    bus.id_use_rs1_i = 0; bus.id_use_rs2_i = 0;
    bus.id_rs1_data_i = 0; bus.id_rs2_data_i = 0;
    bus.id_imm_i = 0; bus.id_pc_i = 0;
    bus.id_alu_src_a_i = 0; bus.id_alu_src_b_i = 0; bus.id_alu_op_i = 0;
    bus.id_rd_i = 0; bus.id_reg_write_i = 0; bus.id_mem_read_i = 0; bus.id_mem_write_i = 0;
    bus.mem_rd_i = 0; bus.mem_reg_write_i = 0; bus.mem_result_i = 0;
    bus.wb_rd_i = 0; bus.wb_reg_write_i = 0; bus.wb_data_i = 0;
    bus.hold_i = 0; bus.flush_i = 0;
  endtask

  task automatic id_instr(input logic [4:0] rs1, input logic u1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic u2, input logic [31:0] d2,
                          input logic [2:0] op, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw);
    bus.id_valid_i = 1; bus.id_rs1_i = rs1; bus.id_use_rs1_i = u1; bus.id_rs1_data_i = d1;
    bus.id_rs2_i = rs2; bus.id_use_rs2_i = u2; bus.id_rs2_data_i = d2;
    bus.id_imm_i = 32'h0000_0040; bus.id_pc_i = 32'h0000_1000;
    bus.id_alu_src_a_i = SRC_A_RS1; bus.id_alu_src_b_i = SRC_B_RS2;
    bus.id_alu_op_i = op; bus.id_rd_i = rd;
    bus.id_reg_write_i = rw; bus.id_mem_read_i = mr; bus.id_mem_write_i = mw;
  endtask

  initial begin
    idle();
    m = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_valid", 64'(bus.ex_valid_o), 64'd0);
    check_val("rst_a", 64'(bus.ex_a_o), 64'd0);
    check_val("rst_b", 64'(bus.ex_b_o), 64'd0);
    check_val("rst_stall", 64'(bus.stall_o), 64'd0);
    #2 rst_n = 1;

    // plain capture
    id_instr(5'd1, 1, 32'd5, 5'd2, 1, 32'd3, ALU_SUB, 5'd5, 1, 0, 0);
    tick();
    idle(); #1;
    check_val("cap_a", 64'(bus.ex_a_o), 64'd5);
    check_val("cap_b", 64'(bus.ex_b_o), 64'd3);
    check_val("cap_op", 64'(bus.ex_alu_op_o), 64'(3'b110));
    check_val("cap_valid", 64'(bus.ex_valid_o), 64'd1);
    tick();

    // forward priority
    id_instr(5'd3, 1, 32'h11, 5'd0, 0, 32'h0, ALU_ADD, 5'd9, 1, 0, 0);
    tick();
    idle();
    bus.mem_rd_i = 5'd3; bus.mem_reg_write_i = 1; bus.mem_result_i = 32'hAA;
    bus.wb_rd_i = 5'd3; bus.wb_reg_write_i = 1; bus.wb_data_i = 32'hBB;
    #1 check_val("fwd_mem", 64'(bus.ex_a_o), 64'h0AA);
    bus.mem_reg_write_i = 0;
    #1 check_val("fwd_wb", 64'(bus.ex_a_o), 64'h0BB);
    bus.mem_reg_write_i = 1; bus.mem_rd_i = 5'd0; bus.wb_rd_i = 5'd0;
    #1 check_val("fwd_x0", 64'(bus.ex_a_o), 64'h011);
    tick();

    // load-use
    idle();
    id_instr(5'd0, 0, 32'h0, 5'd0, 0, 32'h0, ALU_ADD, 5'd4, 1, 1, 0);
    tick();
    id_instr(5'd4, 1, 32'h77, 5'd5, 1, 32'h8, ALU_ADD, 5'd6, 1, 0, 0);
    #1 check_val("lu_stall", 64'(bus.stall_o), 64'd1);
    tick();
    #1;
    check_val("lu_bub_valid", 64'(bus.ex_valid_o), 64'd0);
    check_val("lu_bub_rw", 64'(bus.ex_reg_write_o), 64'd0);
    check_val("lu_bub_stall", 64'(bus.stall_o), 64'd0);
    tick();
    #1;
    check_val("lu_add_valid", 64'(bus.ex_valid_o), 64'd1);
    check_val("lu_add_rd", 64'(bus.ex_rd_o), 64'd6);
    idle();

    // hold refresh
    id_instr(5'd0, 0, 32'h0, 5'd7, 1, 32'h50, ALU_OR, 5'd8, 1, 0, 0);
    tick();
    idle();
    bus.hold_i = 1; bus.wb_rd_i = 5'd7; bus.wb_reg_write_i = 1; bus.wb_data_i = 32'h1234;
    repeat (3) tick();
    bus.hold_i = 0; bus.wb_reg_write_i = 0; bus.wb_rd_i = 0; bus.wb_data_i = 0;
    #1 check_val("hold_b", 64'(bus.ex_b_o), 64'h1234);
    tick();

    // flush during hold
    id_instr(5'd1, 1, 32'h3, 5'd2, 1, 32'h4, ALU_ADD, 5'd10, 1, 0, 1);
    tick();
    idle();
    #1 check_val("pre_flush_mw", 64'(bus.ex_mem_write_o), 64'd1);
    bus.hold_i = 1; bus.flush_i = 1;
    tick();
    #1;
    check_val("flush_valid", 64'(bus.ex_valid_o), 64'd0);
    check_val("flush_rw", 64'(bus.ex_reg_write_o), 64'd0);
    check_val("flush_mw", 64'(bus.ex_mem_write_o), 64'd0);
    idle();

    // reset while a load-use stall is pending
    id_instr(5'd0, 0, 32'h0, 5'd0, 0, 32'h0, ALU_ADD, 5'd12, 1, 1, 0);
    tick();
    id_instr(5'd12, 1, 32'h9, 5'd0, 0, 32'h0, ALU_ADD, 5'd13, 1, 0, 0);
    #1 check_val("mid_stall", 64'(bus.stall_o), 64'd1);
    #2 rst_n = 0;
    #1;
    check_val("mid_rst_stall", 64'(bus.stall_o), 64'd0);
    check_val("mid_rst_valid", 64'(bus.ex_valid_o), 64'd0);
    check_val("mid_rst_a", 64'(bus.ex_a_o), 64'd0);
    m = '0;
    #1 rst_n = 1;
    idle();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      bus.id_valid_i      = ($urandom_range(0, 3) != 0);
      bus.id_rs1_i        = 5'($urandom_range(0, 7));
      bus.id_rs2_i        = 5'($urandom_range(0, 7));
      bus.id_use_rs1_i    = 1'($urandom);
      bus.id_use_rs2_i    = 1'($urandom);
      bus.id_rs1_data_i   = $urandom;
      bus.id_rs2_data_i   = $urandom;
      bus.id_imm_i        = $urandom;
      bus.id_pc_i         = $urandom;
      bus.id_alu_src_a_i  = 1'($urandom);
      bus.id_alu_src_b_i  = 1'($urandom);
      bus.id_alu_op_i     = 3'($urandom);
      bus.id_rd_i         = 5'($urandom_range(0, 7));
      bus.id_reg_write_i  = 1'($urandom);
      bus.id_mem_read_i   = 1'($urandom);
      bus.id_mem_write_i  = 1'($urandom);
      bus.mem_rd_i        = 5'($urandom_range(0, 7));
      bus.mem_reg_write_i = 1'($urandom);
      bus.mem_result_i    = $urandom;
      bus.wb_rd_i         = 5'($urandom_range(0, 7));
      bus.wb_reg_write_i  = 1'($urandom);
      bus.wb_data_i       = $urandom;
      bus.hold_i          = ($urandom_range(0, 4) == 0);
      bus.flush_i         = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
